// File: rtl/pipe_stage_register.sv
// Purpose : one-stage valid/ready pipeline register, optional two-entry skid buffer.
// Latency : one cycle from input acceptance to out_valid when the stage is empty or draining.
// Backpress: SKID_EN=1 registers in_ready (drops only when both entries are full);
//            SKID_EN=0 passes out_ready straight through to in_ready while an entry is held.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   flush                drop every held entry and any entry offered this cycle
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data payload (main register)
//   occupancy            number of held entries, 0..2
module pipe_stage_register #(
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}},
   parameter bit                    SKID_EN     = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            occupancy
);

   // Encoding equals the number of held entries, so occupancy is the state itself.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] main_q;
   logic [DATA_WIDTH-1:0] skid_q;
   logic                  vld_q;
   logic                  rdy_q;
   logic                  in_fire;
   logic                  out_fire;
   logic                  load_main_in;
   logic                  load_main_skid;
   logic                  load_skid;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         // Flush beats any transfer; an out_fire this cycle has still been delivered.
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_nxt    = ST_ONE;
                  load_main_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  load_main_in = 1'b1;
               end else if (in_fire) begin
                  // Without a skid entry in_ready implies out_ready here, so this
                  // branch is only reachable when the skid register exists.
                  if (SKID_EN) begin
                     state_nxt = ST_TWO;
                     load_skid = 1'b1;
                  end
               end else if (out_fire) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (out_fire) begin
                  state_nxt      = ST_ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Handshake outputs are registered from the next state so they never depend
   // combinationally on out_ready in skid mode.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_EMPTY;
         main_q <= RESET_VALUE;
         vld_q  <= 1'b0;
         rdy_q  <= 1'b1;
      end else begin
         state <= state_nxt;
         vld_q <= (state_nxt != ST_EMPTY);
         rdy_q <= (state_nxt != ST_TWO);
         if (load_main_in) begin
            main_q <= in_data;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
      end
   end

   generate
      if (SKID_EN) begin : g_skid
         logic [DATA_WIDTH-1:0] skid_r;

         always_ff @(posedge clk) begin
            if (reset) begin
               skid_r <= RESET_VALUE;
            end else if (load_skid) begin
               skid_r <= in_data;
            end
         end

         assign skid_q   = skid_r;
         assign in_ready = rdy_q;
      end else begin : g_pass
         // No skid storage: the main-register reload path is never selected.
         assign skid_q   = main_q;
         assign in_ready = (state == ST_EMPTY) | out_ready;
      end
   endgenerate

   assign out_valid = vld_q;
   assign out_data  = main_q;
   assign occupancy = state;

endmodule

// File: tb/tb_pipe_stage_register.sv
// Purpose : directed checks of both stage modes plus a queue-scoreboard random run.
// Latency : n/a (testbench).
// Backpress: n/a (testbench drives out_ready directly).
module tb_pipe_stage_register;

   logic        clk = 1'b0;
   logic        reset;

   logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [31:0] a_in_data, a_out_data;
   logic [1:0]  a_occ;

   logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [31:0] b_in_data, b_out_data;
   logic [1:0]  b_occ;

   int          vectors = 0;
   int          miscompares = 0;

   logic [31:0] qa[$];
   logic [31:0] qb[$];
   logic        ea_rdy, ea_vld, eb_rdy, eb_vld;
   logic        a_if, a_of, b_if, b_of;

   always #5 clk = ~clk;

   pipe_stage_register #(
      .DATA_WIDTH (32),
      .RESET_VALUE(32'hDEAD_BEEF),
      .SKID_EN    (1'b1)
   ) u_skid (
      .clk      (clk),
      .reset    (reset),
      .flush    (a_flush),
      .in_valid (a_in_valid),
      .in_ready (a_in_ready),
      .in_data  (a_in_data),
      .out_valid(a_out_valid),
      .out_ready(a_out_ready),
      .out_data (a_out_data),
      .occupancy(a_occ)
   );

   pipe_stage_register #(
      .DATA_WIDTH(32),
      .SKID_EN   (1'b0)
   ) u_pass (
      .clk      (clk),
      .reset    (reset),
      .flush    (b_flush),
      .in_valid (b_in_valid),
      .in_ready (b_in_ready),
      .in_data  (b_in_data),
      .out_valid(b_out_valid),
      .out_ready(b_out_ready),
      .out_data (b_out_data),
      .occupancy(b_occ)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   initial begin
      reset      = 1'b1;
      a_flush    = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
      b_flush    = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_a_vld", a_out_valid, 1'b0);
      chk("rst_a_occ", a_occ, 2'd0);
      chk("rst_a_rdy", a_in_ready, 1'b1);
      chk("rst_a_dat", a_out_data, 32'hDEAD_BEEF);
      chk("rst_b_dat", b_out_data, 32'h0);
      chk("rst_b_rdy", b_in_ready, 1'b1);
      chk("rst_b_occ", b_occ, 2'd0);

      // Streaming through the skid stage.
      a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 32'h1;
      @(negedge clk);
      chk("str_vld1", a_out_valid, 1'b1);
      chk("str_dat1", a_out_data, 32'h1);
      chk("str_occ1", a_occ, 2'd1);
      a_in_data = 32'h2;
      @(negedge clk);
      chk("str_dat2", a_out_data, 32'h2);
      chk("str_occ2", a_occ, 2'd1);
      a_in_data = 32'h3;
      @(negedge clk);
      chk("str_dat3", a_out_data, 32'h3);
      chk("str_occ3", a_occ, 2'd1);
      chk("str_rdy3", a_in_ready, 1'b1);
      a_in_valid = 1'b0;
      @(negedge clk);
      chk("str_vld_end", a_out_valid, 1'b0);
      chk("str_occ_end", a_occ, 2'd0);

      // Backpressure fills the skid entry.
      a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hA;
      @(negedge clk);
      chk("bp_occ1", a_occ, 2'd1);
      chk("bp_datA", a_out_data, 32'hA);
      chk("bp_rdy1", a_in_ready, 1'b1);
      a_in_data = 32'hB;
      @(negedge clk);
      chk("bp_occ2", a_occ, 2'd2);
      chk("bp_rdy2", a_in_ready, 1'b0);
      chk("bp_vld2", a_out_valid, 1'b1);
      chk("bp_hold_A", a_out_data, 32'hA);
      a_in_data = 32'hC; a_out_ready = 1'b1;
      @(negedge clk);
      chk("bp_datB", a_out_data, 32'hB);
      chk("bp_occB", a_occ, 2'd1);
      chk("bp_rdy_back", a_in_ready, 1'b1);
      a_in_valid = 1'b0;
      @(negedge clk);
      chk("bp_drain_vld", a_out_valid, 1'b0);
      chk("bp_drain_occ", a_occ, 2'd0);

      // Flush from TWO with an offered payload.
      a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h11;
      @(negedge clk);
      a_in_data = 32'h22;
      @(negedge clk);
      chk("fl_occ2", a_occ, 2'd2);
      chk("fl_dat11", a_out_data, 32'h11);
      a_flush = 1'b1; a_in_data = 32'h33;
      @(negedge clk);
      chk("fl_occ0", a_occ, 2'd0);
      chk("fl_vld0", a_out_valid, 1'b0);
      chk("fl_rdy", a_in_ready, 1'b1);
      a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
      @(negedge clk);
      chk("fl_quiet", a_out_valid, 1'b0);
      // Flush from ONE while an input is actually accepted.
      a_in_valid = 1'b1; a_in_data = 32'h44; a_out_ready = 1'b0;
      @(negedge clk);
      chk("fl1_occ", a_occ, 2'd1);
      chk("fl1_dat", a_out_data, 32'h44);
      a_flush = 1'b1; a_in_data = 32'h55;
      @(negedge clk);
      chk("fl1_occ0", a_occ, 2'd0);
      chk("fl1_vld0", a_out_valid, 1'b0);
      a_flush = 1'b0; a_in_data = 32'h66;

      // Reset with a payload held.
      @(negedge clk);
      chk("rm_occ", a_occ, 2'd1);
      chk("rm_dat", a_out_data, 32'h66);
      a_in_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; a_out_ready = 1'b1;
      chk("rm_occ0", a_occ, 2'd0);
      chk("rm_vld0", a_out_valid, 1'b0);
      chk("rm_dat_rst", a_out_data, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("rm_quiet", a_out_valid, 1'b0);

      // Pass-through ready mode.
      b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 32'h5;
      #1 chk("pt_rdy_empty", b_in_ready, 1'b1);
      @(negedge clk);
      chk("pt_occ5", b_occ, 2'd1);
      chk("pt_dat5", b_out_data, 32'h5);
      b_in_data = 32'h6;
      #1 chk("pt_rdy_blk", b_in_ready, 1'b0);
      @(negedge clk);
      chk("pt_hold5", b_out_data, 32'h5);
      chk("pt_hold_occ", b_occ, 2'd1);
      b_out_ready = 1'b1;
      #1 chk("pt_rdy_pass", b_in_ready, 1'b1);
      @(negedge clk);
      chk("pt_dat6", b_out_data, 32'h6);
      chk("pt_vld6", b_out_valid, 1'b1);
      b_in_data = 32'h7;
      @(negedge clk);
      chk("pt_dat7", b_out_data, 32'h7);
      chk("pt_occ7", b_occ, 2'd1);
      b_in_data = 32'h8;
      @(negedge clk);
      chk("pt_dat8", b_out_data, 32'h8);
      b_in_valid = 1'b0;
      @(negedge clk);
      chk("pt_vld_end", b_out_valid, 1'b0);
      chk("pt_occ_end", b_occ, 2'd0);

      // Random traffic against a queue scoreboard, both stages at once.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         a_in_valid  = 1'($urandom_range(0, 1));
         a_in_data   = $urandom;
         a_out_ready = ($urandom_range(0, 3) != 0);
         a_flush     = ($urandom_range(0, 19) == 0);
         b_in_valid  = 1'($urandom_range(0, 1));
         b_in_data   = $urandom;
         b_out_ready = ($urandom_range(0, 3) != 0);
         b_flush     = ($urandom_range(0, 19) == 0);
         #1;
         ea_rdy = (qa.size() < 2);
         ea_vld = (qa.size() != 0);
         eb_rdy = (qb.size() == 0) | b_out_ready;
         eb_vld = (qb.size() != 0);
         chk("rnd_a_rdy", a_in_ready, ea_rdy);
         chk("rnd_a_vld", a_out_valid, ea_vld);
         chk("rnd_a_occ", a_occ, 64'(qa.size()));
         if (ea_vld) chk("rnd_a_dat", a_out_data, qa[0]);
         chk("rnd_b_rdy", b_in_ready, eb_rdy);
         chk("rnd_b_vld", b_out_valid, eb_vld);
         chk("rnd_b_occ", b_occ, 64'(qb.size()));
         if (eb_vld) chk("rnd_b_dat", b_out_data, qb[0]);
         a_if = a_in_valid & ea_rdy;
         a_of = ea_vld & a_out_ready;
         b_if = b_in_valid & eb_rdy;
         b_of = eb_vld & b_out_ready;
         @(posedge clk);
         if (a_flush) qa.delete();
         else begin
            if (a_of) void'(qa.pop_front());
            if (a_if) qa.push_back(a_in_data);
         end
         if (b_flush) qb.delete();
         else begin
            if (b_of) void'(qb.pop_front());
            if (b_if) qb.push_back(b_in_data);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
